// File: rtl/peripheral_spram_tl_burst.sv
// Single-port scratchpad RAM with a burst-capable BIU slave front end.
// Issues one beat per cycle for SINGLE/INCR/WRAP transfers and flags illegal or out-of-range accesses.
module peripheral_spram_tl_burst #(
    parameter int XLEN  = 64,
    parameter int PLEN  = 64,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            biu_stb_i,
    output logic            biu_stb_ack_o,
    output logic            biu_d_ack_o,
    input  logic [PLEN-1:0] biu_adri_i,
    output logic [PLEN-1:0] biu_adro_o,
    input  logic [2:0]      biu_size_i,
    input  logic [2:0]      biu_type_i,
    input  logic [2:0]      biu_prot_i,
    input  logic            biu_lock_i,
    input  logic            biu_we_i,
    input  logic [XLEN-1:0] biu_d_i,
    output logic [XLEN-1:0] biu_q_o,
    output logic            biu_ack_o,
    output logic            biu_err_o
);
    localparam int BYTES = XLEN / 8;
    localparam int B     = $clog2(BYTES);
    localparam int AW    = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    function automatic logic [4:0] beat_count(input logic [2:0] t);
        case (t)
            3'd2, 3'd3: return 5'd4;
            3'd4, 3'd5: return 5'd8;
            3'd6, 3'd7: return 5'd16;
            default:    return 5'd1;
        endcase
    endfunction

    function automatic logic [BYTES-1:0] byte_en(input logic [2:0] size, input logic [B-1:0] off);
        logic [BYTES-1:0] m;
        case (size)
            3'd0:    m = BYTES'(1);
            3'd1:    m = BYTES'(3);
            3'd2:    m = BYTES'(15);
            default: m = '1;
        endcase
        return m << off;
    endfunction

    function automatic logic acc_error(input logic [PLEN-1:0] adr, input logic [2:0] size,
                                       input logic [2:0] t);
        logic [PLEN-1:0] align_mask;
        align_mask = (PLEN'(1) << size) - PLEN'(1);
        return (int'(size) > B) || ((adr & align_mask) != '0) || (t == 3'd1) ||
               ((t != 3'd0) && (int'(size) != B)) || ((adr >> (B + AW)) != '0);
    endfunction

    // Wrapping types have bit 0 set; the wrap block is N words, aligned to its own size.
    function automatic logic [PLEN-1:0] next_adr(input logic [PLEN-1:0] a, input logic [2:0] t);
        logic [PLEN-1:0] inc;
        logic [PLEN-1:0] mask;
        inc  = a + PLEN'(BYTES);
        mask = (PLEN'(beat_count(t)) << B) - PLEN'(1);
        if (t[0]) begin
            return (a & ~mask) | (inc & mask);
        end else begin
            return inc;
        end
    endfunction

    logic [1:0]       state_r, state_nxt_s;
    logic [PLEN-1:0]  adr_r, adr_nxt_s;
    logic [4:0]       cnt_r, cnt_nxt_s;
    logic [2:0]       size_r, size_nxt_s;
    logic [2:0]       type_r, type_nxt_s;
    logic             we_r, we_nxt_s;
    logic             ack_r, err_r;
    logic [PLEN-1:0]  adro_r;
    logic [XLEN-1:0]  q_r;
    logic [XLEN-1:0]  mem_r [DEPTH];

    logic             accept_s, acc_err_s, in_burst_s, ovf_s;
    logic             beat_valid_s, beat_err_s, beat_we_s, ram_we_s, ram_re_s;
    logic [PLEN-1:0]  beat_adr_s;
    logic [2:0]       beat_size_s;
    logic [4:0]       accept_cnt_s;
    logic [AW-1:0]    ram_idx_s;
    logic [BYTES-1:0] be_s;
    logic             unused_s;

    assign unused_s     = ^{biu_prot_i, biu_lock_i};

    assign accept_s     = rst && biu_stb_i && (state_r == ST_IDLE);
    assign acc_err_s    = acc_error(biu_adri_i, biu_size_i, biu_type_i);
    assign accept_cnt_s = beat_count(biu_type_i);
    assign in_burst_s   = (state_r == ST_READ) || (state_r == ST_WRITE);
    assign ovf_s        = in_burst_s && ((adr_r >> (B + AW)) != '0);

    assign beat_adr_s   = in_burst_s ? adr_r  : biu_adri_i;
    assign beat_size_s  = in_burst_s ? size_r : biu_size_i;
    assign beat_we_s    = in_burst_s ? we_r   : biu_we_i;
    assign beat_valid_s = (accept_s && !acc_err_s) || (in_burst_s && !ovf_s);
    assign beat_err_s   = (accept_s && acc_err_s) || ovf_s;
    assign ram_we_s     = beat_valid_s && beat_we_s;
    assign ram_re_s     = beat_valid_s && !beat_we_s;
    assign ram_idx_s    = beat_adr_s[B +: AW];
    assign be_s         = byte_en(beat_size_s, beat_adr_s[B-1:0]);

    // Write data is taken on accept (even for a rejected write) and on every WRITE cycle.
    assign biu_stb_ack_o = accept_s;
    assign biu_d_ack_o   = (accept_s && biu_we_i) || (rst && (state_r == ST_WRITE));
    assign biu_ack_o     = ack_r;
    assign biu_err_o     = err_r;
    assign biu_adro_o    = adro_r;
    assign biu_q_o       = q_r;

    // Next-state, burst address and remaining-beat bookkeeping
    always_comb begin
        state_nxt_s = state_r;
        adr_nxt_s   = adr_r;
        cnt_nxt_s   = cnt_r;
        size_nxt_s  = size_r;
        type_nxt_s  = type_r;
        we_nxt_s    = we_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    size_nxt_s = biu_size_i;
                    type_nxt_s = biu_type_i;
                    we_nxt_s   = biu_we_i;
                    if (acc_err_s) begin
                        state_nxt_s = ST_ERR;
                        adr_nxt_s   = biu_adri_i;
                        cnt_nxt_s   = 5'd0;
                    end else if (accept_cnt_s == 5'd1) begin
                        state_nxt_s = ST_IDLE;
                        adr_nxt_s   = next_adr(biu_adri_i, biu_type_i);
                        cnt_nxt_s   = 5'd0;
                    end else begin
                        state_nxt_s = biu_we_i ? ST_WRITE : ST_READ;
                        adr_nxt_s   = next_adr(biu_adri_i, biu_type_i);
                        cnt_nxt_s   = accept_cnt_s - 5'd1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ, ST_WRITE: begin
                if (ovf_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 5'd0;
                end else if (cnt_r == 5'd1) begin
                    state_nxt_s = ST_IDLE;
                    adr_nxt_s   = next_adr(adr_r, type_r);
                    cnt_nxt_s   = 5'd0;
                end else begin
                    adr_nxt_s   = next_adr(adr_r, type_r);
                    cnt_nxt_s   = cnt_r - 5'd1;
                end
            end
            ST_ERR:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state, latched request and registered beat responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            adr_r   <= '0;
            cnt_r   <= 5'd0;
            size_r  <= 3'd0;
            type_r  <= 3'd0;
            we_r    <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            adro_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            adr_r   <= adr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            size_r  <= size_nxt_s;
            type_r  <= type_nxt_s;
            we_r    <= we_nxt_s;
            ack_r   <= beat_valid_s;
            err_r   <= beat_err_s;
            if (beat_valid_s || beat_err_s) begin
                adro_r <= beat_adr_s;
            end else begin
                adro_r <= adro_r;
            end
        end
    end

    // RAM array: byte-lane writes, contents are never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (ram_we_s && be_s[i]) begin
                mem_r[ram_idx_s][8*i +: 8] <= biu_d_i[8*i +: 8];
            end
        end
    end

    // Read data register, refreshed only by read beats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= '0;
        end else if (ram_re_s) begin
            q_r <= mem_r[ram_idx_s];
        end else begin
            q_r <= q_r;
        end
    end
endmodule

// File: tb/tb_peripheral_spram_tl_burst.sv
// Self-checking bench for peripheral_spram_tl_burst: a reference memory model fills a
// scoreboard of expected ack/err beats that a negedge monitor consumes.
module tb_peripheral_spram_tl_burst;
    logic        clk;
    logic        rst;
    logic        biu_stb_i;
    logic        biu_stb_ack_o;
    logic        biu_d_ack_o;
    logic [63:0] biu_adri_i;
    logic [63:0] biu_adro_o;
    logic [2:0]  biu_size_i;
    logic [2:0]  biu_type_i;
    logic [2:0]  biu_prot_i;
    logic        biu_lock_i;
    logic        biu_we_i;
    logic [63:0] biu_d_i;
    logic [63:0] biu_q_o;
    logic        biu_ack_o;
    logic        biu_err_o;

    peripheral_spram_tl_burst #(.XLEN(64), .PLEN(64), .DEPTH(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .biu_stb_i    (biu_stb_i),
        .biu_stb_ack_o(biu_stb_ack_o),
        .biu_d_ack_o  (biu_d_ack_o),
        .biu_adri_i   (biu_adri_i),
        .biu_adro_o   (biu_adro_o),
        .biu_size_i   (biu_size_i),
        .biu_type_i   (biu_type_i),
        .biu_prot_i   (biu_prot_i),
        .biu_lock_i   (biu_lock_i),
        .biu_we_i     (biu_we_i),
        .biu_d_i      (biu_d_i),
        .biu_q_o      (biu_q_o),
        .biu_ack_o    (biu_ack_o),
        .biu_err_o    (biu_err_o)
    );

    typedef struct {
        logic        err;
        logic [63:0] adro;
        logic        qv;
        logic [63:0] q;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] model_mem [1024];
    logic [63:0] wr_data [16];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          dack_cnt = 0;
    int          exp_dacks = 0;
    int          w;
    int          c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected responses
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic err, input logic [63:0] adro, input logic qv,
                            input logic [63:0] q, input int at);
        exp_t e;
        e.err  = err;
        e.adro = adro;
        e.qv   = qv;
        e.q    = q;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_stb_ack"}, 64'(biu_stb_ack_o), 64'd0);
        chk({pfx, "_d_ack"},   64'(biu_d_ack_o),   64'd0);
        chk({pfx, "_ack"},     64'(biu_ack_o),     64'd0);
        chk({pfx, "_err"},     64'(biu_err_o),     64'd0);
        chk({pfx, "_adro"},    biu_adro_o,         64'd0);
        chk({pfx, "_q"},       biu_q_o,            64'd0);
    endtask

    // Drives one request, models its outcome into the scoreboard and feeds write beats.
    // Entered and left just after a rising edge, so requests can be issued back to back.
    task automatic run_req(input logic we, input logic [63:0] adr, input logic [2:0] size,
                           input logic [2:0] typ, output int waits);
        int          n;
        int          bytes;
        int          nd;
        int          ndexp;
        int          c0;
        logic        err;
        logic [63:0] a;
        logic [63:0] base;
        biu_stb_i  = 1'b1;
        biu_we_i   = we;
        biu_adri_i = adr;
        biu_size_i = size;
        biu_type_i = typ;
        biu_d_i    = wr_data[0];
        waits      = 0;
        @(negedge clk);
        while (!biu_stb_ack_o && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        chk("accept", 64'(biu_stb_ack_o), 64'd1);
        c0 = cyc;
        case (typ)
            3'd2, 3'd3: n = 4;
            3'd4, 3'd5: n = 8;
            3'd6, 3'd7: n = 16;
            default:    n = 1;
        endcase
        bytes = 1 << size;
        err = (size > 3'd3) || ((adr % 64'(bytes)) != 64'd0) || (typ == 3'd1) ||
              ((typ != 3'd0) && (size != 3'd3)) || (adr >= 64'h2000);
        if (err) begin
            push_exp(1'b1, adr, 1'b0, 64'd0, c0 + 1);
        end else begin
            base = adr - (adr % 64'(n * 8));
            for (int k = 0; k < n; k++) begin
                if (typ[0]) a = base + ((adr - base + 64'(k * 8)) % 64'(n * 8));
                else        a = adr + 64'(k * 8);
                if (a >= 64'h2000) begin
                    push_exp(1'b1, a, 1'b0, 64'd0, c0 + k + 1);
                    break;
                end
                if (we) begin
                    for (int b = 0; b < 8; b++) begin
                        if (b >= int'(a % 64'd8) && b < int'(a % 64'd8) + bytes)
                            model_mem[a[12:3]][8*b +: 8] = wr_data[k][8*b +: 8];
                    end
                end
                push_exp(1'b0, a, !we, model_mem[a[12:3]], c0 + k + 1);
            end
        end
        ndexp = we ? (err ? 1 : n) : 0;
        exp_dacks += ndexp;
        nd = 0;
        @(posedge clk); #1;
        biu_stb_i = 1'b0;
        if (we) begin
            nd = 1;
            biu_d_i = wr_data[1];
        end
        while (nd < ndexp) begin
            @(negedge clk);
            chk("d_ack_beat", 64'(biu_d_ack_o), 64'd1);
            @(posedge clk); #1;
            nd++;
            biu_d_i = wr_data[nd % 16];
        end
    endtask

    // Response monitor: every ack/err beat must match the scoreboard head, cycle included
    always @(negedge clk) begin
        if (biu_d_ack_o) dack_cnt <= dack_cnt + 1;
        if (biu_ack_o || biu_err_o) begin
            chk("ack_err_excl", 64'(biu_ack_o & biu_err_o), 64'd0);
            chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("resp_is_err", 64'(biu_err_o), 64'(mon_e.err));
                chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("resp_adro", biu_adro_o, mon_e.adro);
                if (mon_e.qv) chk("resp_q", biu_q_o, mon_e.q);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        biu_stb_i  = 1'b1;
        biu_adri_i = 64'd0;
        biu_size_i = 3'd3;
        biu_type_i = 3'd0;
        biu_prot_i = 3'd0;
        biu_lock_i = 1'b0;
        biu_we_i   = 1'b1;
        biu_d_i    = 64'd0;
        repeat (3) begin
            @(negedge clk);
            chk_quiet("in_rst");
        end
        @(posedge clk); #1;
        biu_stb_i = 1'b0;
        rst       = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_quiet("post_rst");
        end
        @(posedge clk); #1;

        // Preload words 0..7, WRAP4 block at 0x20..0x38 holds 1..4
        wr_data[0] = 64'hDEAD_BEEF_0000_0000;
        wr_data[1] = 64'h0101_0101_0101_0101;
        wr_data[2] = 64'h0;
        wr_data[3] = 64'h3333;
        for (int k = 4; k < 8; k++) wr_data[k] = 64'(k - 3);
        run_req(1'b1, 64'h0, 3'd3, 3'd4, w);

        wr_data[0] = 64'h0000_0000_AA00_0000;
        run_req(1'b1, 64'h13, 3'd0, 3'd0, w);
        run_req(1'b0, 64'h10, 3'd3, 3'd0, w);
        run_req(1'b0, 64'h0, 3'd3, 3'd2, w);
        run_req(1'b0, 64'h38, 3'd3, 3'd3, w);

        wr_data[0] = 64'hBEEF_0000_0000_0000;
        run_req(1'b1, 64'h16, 3'd1, 3'd0, w);
        run_req(1'b0, 64'h10, 3'd3, 3'd0, w);

        for (int k = 0; k < 16; k++) wr_data[k] = 64'h1234_5678_0000_0000 | 64'(k * 17);
        run_req(1'b1, 64'h100, 3'd3, 3'd4, w);
        run_req(1'b0, 64'h100, 3'd3, 3'd4, w);
        chk("b2b_accept_wait", 64'(w), 64'd0);

        for (int k = 0; k < 16; k++) wr_data[k] = 64'h0000_0080_0000_0000 | 64'(k);
        run_req(1'b1, 64'h158, 3'd3, 3'd5, w);
        run_req(1'b0, 64'h140, 3'd3, 3'd4, w);

        // Rejected writes must leave RAM intact; 0x2000 would alias word 0
        for (int k = 0; k < 16; k++) wr_data[k] = 64'hBAD0_BAD0_BAD0_BAD0;
        run_req(1'b1, 64'h2000, 3'd3, 3'd0, w);
        run_req(1'b1, 64'h12, 3'd2, 3'd0, w);
        run_req(1'b1, 64'h10, 3'd3, 3'd1, w);
        run_req(1'b1, 64'h20, 3'd2, 3'd2, w);
        run_req(1'b0, 64'h0, 3'd3, 3'd4, w);

        wr_data[0] = 64'h1FF0_1FF0_1FF0_1FF0;
        run_req(1'b1, 64'h1FF0, 3'd3, 3'd0, w);
        wr_data[0] = 64'h1FF8_1FF8_1FF8_1FF8;
        run_req(1'b1, 64'h1FF8, 3'd3, 3'd0, w);
        run_req(1'b0, 64'h1FF0, 3'd3, 3'd2, w);

        // Reset during an INCR16 write, right after the third beat is taken
        for (int k = 0; k < 16; k++) wr_data[k] = 64'hA5A5_0000_0000_0000 | 64'(k);
        run_req(1'b1, 64'h200, 3'd3, 3'd6, w);
        for (int k = 0; k < 16; k++) wr_data[k] = 64'hC3C3_0000_0000_0000 | 64'(k);
        biu_stb_i  = 1'b1;
        biu_we_i   = 1'b1;
        biu_adri_i = 64'h200;
        biu_size_i = 3'd3;
        biu_type_i = 3'd6;
        biu_d_i    = wr_data[0];
        @(negedge clk);
        chk("mid_accept", 64'(biu_stb_ack_o), 64'd1);
        c = cyc;
        for (int k = 0; k < 3; k++) model_mem[64 + k] = wr_data[k];
        push_exp(1'b0, 64'h200, 1'b0, 64'd0, c + 1);
        push_exp(1'b0, 64'h208, 1'b0, 64'd0, c + 2);
        exp_dacks += 3;
        @(posedge clk); #1;
        biu_stb_i = 1'b0;
        biu_d_i   = wr_data[1];
        @(posedge clk); #1;
        biu_d_i   = wr_data[2];
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_quiet("mid_rst");
        repeat (2) begin
            @(negedge clk);
            chk_quiet("mid_hold");
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("mid_rel");
        @(posedge clk); #1;
        run_req(1'b0, 64'h200, 3'd3, 3'd6, w);

        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        chk("d_ack_total", 64'(dack_cnt), 64'(exp_dacks));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
